// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: FSM state encodings and frame
//                geometry, used by both the receiver and the transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Number of payload bits in one frame
    localparam int c_DATA_BITS = 8;

    // FSM state encodings (3-bit; encoding 3'd7 is unused)
    typedef logic [2:0] uart_state_t;

    localparam uart_state_t c_IDLE       = 3'd0;
    localparam uart_state_t c_START      = 3'd1;
    localparam uart_state_t c_DATA       = 3'd2;
    localparam uart_state_t c_PARITY     = 3'd3;
    localparam uart_state_t c_STOP       = 3'd4;
    localparam uart_state_t c_DONE       = 3'd5;
    localparam uart_state_t c_BREAK_WAIT = 3'd6;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line.
//                Both flops reset to 1 so the line reads as idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation into the i_clk domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 asynchronous serial receiver. Oversamples the line with
//                a per-bit counter and samples every bit at its midpoint.
//                Good frames produce a one-cycle o_rx_dv strobe; a zero stop
//                bit produces a single o_frame_err strobe and the receiver
//                then waits for the line to return high.
//                Build option UART_RX_PARITY_EN adds an even-parity bit
//                between data and stop and the o_parity_err strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_active,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_frame_err
);

    localparam int             c_CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_CW-1:0] c_HALF = c_CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [2:0]      c_LAST_IDX = 3'(c_DATA_BITS - 1);

    logic                   w_rx_s;
    uart_state_t            r_state;
    logic [c_CW-1:0]        r_count;
    logic [2:0]             r_idx;
    logic [c_DATA_BITS-1:0] r_shift;
    logic                   r_rx_dv;
    logic [7:0]             r_rx_byte;
    logic                   r_rx_active;
    logic                   r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                   r_parity_bit;
    logic                   r_parity_err;
`endif

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx_serial),
        .o_q     (w_rx_s)
    );

    // Frame-reception FSM with registered outputs; strobes default low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rx_dv     <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_rx_active <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    r_count <= '0;
                    r_idx   <= '0;
                    if (!w_rx_s) begin
                        r_state     <= c_START;
                        r_rx_active <= 1'b1;
                    end
                end

                c_START: begin
                    if (r_count == c_HALF) begin
                        r_count <= '0;
                        if (!w_rx_s) begin
                            r_state <= c_DATA;
                        end else begin
                            // Line went high before mid-start: a glitch
                            r_state     <= c_IDLE;
                            r_rx_active <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end

                c_DATA: begin
                    if (r_count == c_LAST) begin
                        r_count        <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == c_LAST_IDX) begin
                            r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= c_PARITY;
`else
                            r_state <= c_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                c_PARITY: begin
                    if (r_count == c_LAST) begin
                        r_count      <= '0;
                        r_parity_bit <= w_rx_s;
                        r_state      <= c_STOP;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end
`endif

                c_STOP: begin
                    if (r_count == c_LAST) begin
                        r_count <= '0;
                        if (w_rx_s) begin
                            r_state <= c_DONE;
                        end else begin
                            // Error strobe lands in the first BREAK_WAIT cycle
                            r_state     <= c_BREAK_WAIT;
                            r_frame_err <= 1'b1;
                            r_rx_active <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end

                c_DONE: begin
                    r_rx_byte   <= r_shift;
                    r_rx_dv     <= 1'b1;
                    r_rx_active <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= ^{r_shift, r_parity_bit};
`endif
                    r_state     <= c_IDLE;
                end

                c_BREAK_WAIT: begin
                    // Hold here while the line stays low so a break
                    // produces only one error strobe
                    r_rx_active <= 1'b0;
                    if (w_rx_s) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state     <= c_IDLE;
                    r_count     <= '0;
                    r_idx       <= '0;
                    r_rx_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_dv     = r_rx_dv;
    assign o_rx_byte   = r_rx_byte;
    assign o_rx_active = r_rx_active;
    assign o_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Asynchronous serial receiver; the far-end counterpart of the team's UART transmitter. Oversamples the incoming line with a per-bit clock counter and samples each bit at its midpoint. Reconstructs 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Presents each byte with a one-cycle valid strobe to downstream logic, such as a command decoder or FIFO.

Parameters:
CLKS_PER_BIT, 87, i_clk cycles per bit (i_clk frequency / baud); legal range >= 4.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rx_serial  input  1  serial line, asynchronous to i_clk, idles high
o_rx_dv  output  1  one-cycle strobe: o_rx_byte holds a good frame
o_rx_byte  output  8  last received byte; holds until the next good frame
o_rx_active  output  1  high from start-bit detect until frame end
o_frame_err  output  1  one-cycle strobe: stop bit sampled as 0

Behaviour:
- Reset (async assert, sync release): state IDLE; o_rx_dv=0, o_rx_byte=8'h00, o_rx_active=0, o_frame_err=0; counters 0; synchronizer flops preset to 1 (idle line).
- i_rx_serial passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 cycles of input latency.
- Clock counter width: $clog2(CLKS_PER_BIT)+1. Bit index: 3 bits. HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: count=0, idx=0. If rx_s==0, go to START and set o_rx_active=1.
- START: count up. At count==HALF, sample rx_s. If 0, count=0 and go to DATA. If 1, treat as a glitch: clear o_rx_active and return to IDLE with no strobe.
- DATA: count up to CLKS_PER_BIT-1, then shift rx_s into bit idx (LSB first) and set count=0. If idx==7, go to STOP; otherwise idx++.
- STOP: at count==CLKS_PER_BIT-1, sample rx_s. If 1, go to DONE. If 0, go to BREAK_WAIT.
- DONE (1 cycle): load o_rx_byte, pulse o_rx_dv, clear o_rx_active, go to IDLE.
- BREAK_WAIT: pulse o_frame_err in the entry cycle and clear o_rx_active. o_rx_byte is not updated. Stay until rx_s==1, then go to IDLE. This prevents a held-low line from producing repeated errors.
- Latency: o_rx_dv asserts about 9.5 bit periods + 3 cycles after the falling edge of the start bit on i_rx_serial.
- Back-to-back frames: IDLE is re-entered before the stop bit ends, so a start edge immediately after the stop bit is accepted.
- o_rx_dv and o_frame_err are never high together. Each is high for exactly one cycle per frame.
- Reset mid-frame: immediate return to IDLE. The partial byte is discarded and no strobe is issued.
- Undefined state encodings recover to IDLE.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and samples one even-parity bit at CLKS_PER_BIT-1. A new output o_parity_err (1 bit, reset 0) pulses in DONE when the XOR of the 8 data bits and the parity bit is 1. On a parity error, o_rx_dv still pulses and o_rx_byte is still updated. Frame length becomes 11 bits.
- Undefined: no PARITY state and no o_parity_err port; 10-bit frames.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT; 3-bit encoding) and localparam DATA_BITS=8. The transmitter shares this package.
- Sub-module uart_rx_sync: 2-flop synchronizer with async active-low reset presetting both flops to 1.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Drive 8'hA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> one o_rx_dv pulse with o_rx_byte=8'hA5; o_frame_err stays 0.
2. Send 8'h00 then 8'hFF back-to-back with no idle gap -> two o_rx_dv pulses, bytes 8'h00 then 8'hFF.
3. Pulse the line low for 5 cycles only, then return it high -> no strobe; o_rx_active rises then falls; FSM back in IDLE.
4. Send 8'h3C with the stop bit forced to 0, then hold the line low for 40 bit times -> exactly one o_frame_err pulse and o_rx_byte unchanged. After the line returns high, a following 8'h55 is received correctly.
5. Assert i_rst_n low at data bit 4 of 8'h81 -> all outputs 0 immediately; a subsequent 8'h81 is received correctly.
6. With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> o_rx_dv pulses, o_rx_byte=8'h07, and o_parity_err pulses. Send 8'h07 with parity bit 1 -> o_parity_err stays 0.
